multicycle_adder: RTL

Parametrised multi-cycle ripple-carry adder. It computes `a + b + cin` over `WIDTH/CHUNK` clock cycles, adding one `CHUNK`-bit slice per cycle through a small ripple-carry slice adder. Operand capture and result delivery use a start/busy/done handshake. It is the sequential, width-generic successor of the 8-bit ripple-carry adder: area scales with `CHUNK`, not `WIDTH`.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/chunk_adder.sv | 31 +++
 rtl/multicycle_adder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder family: controller state
// encoding and helpers that derive the slice count and the slice-index
// width from the WIDTH/CHUNK parameters.
package adder_pkg;

   // Controller states: wait for a request, add slices, present the result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of CHUNK-bit slices in a WIDTH-bit operand. A non-positive
   // CHUNK is caught by the elaboration check in the top, so this only
   // guards the division.
   function automatic int calcNchunk(input int width, input int chunk);
      return (chunk < 1) ? 1 : (width / chunk);
   endfunction

   // Width of the slice index counter, never less than one bit so that the
   // single-slice configuration still has a legal counter.
   function automatic int calcIdxWidth(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice adder. One full-adder cell
// per bit. Besides the carry out it exposes the carry into the top bit,
// which the top uses to derive signed overflow on the last slice.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] w_carry;

   assign w_carry[0] = ci;

   // Ripple chain: each cell produces its sum bit and passes a carry up
   genvar i;
   generate
      for (i = 0; i < CHUNK; i++) begin : g_cell
         assign s[i]         = x[i] ^ y[i] ^ w_carry[i];
         assign w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
      end
   endgenerate

   assign co    = w_carry[CHUNK];
   assign c_msb = w_carry[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple-carry adder: computes a + b + cin one CHUNK-bit slice
// per clock over WIDTH/CHUNK cycles, behind a start/busy/done handshake.
// Optional build macro: MULTICYCLE_ADDER_OVF_EN adds a registered signed
// overflow output (ovf).
module multicycle_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NCHUNK = calcNchunk(WIDTH, CHUNK);
   localparam int IDXW   = calcIdxWidth(NCHUNK);

   // Reject configurations whose slices would not tile the operand exactly
   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_badParams
         $fatal(1, "multicycle_adder: WIDTH must be a multiple of CHUNK and CHUNK must be >= 1");
      end
   endgenerate

   state_t           r_state;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic             r_carry;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic [CHUNK-1:0] w_sliceA;
   logic [CHUNK-1:0] w_sliceB;
   logic [CHUNK-1:0] w_sliceSum;
   logic             w_sliceCo;
   logic [WIDTH-1:0] w_workNext;
   logic             w_lastSlice;

`ifdef MULTICYCLE_ADDER_OVF_EN
   logic             r_ovf;
   logic             w_sliceCmsb;
`endif

   // Slice mux: pick operand slice k out of the captured operands
   always_comb begin
      w_sliceA = '0;
      w_sliceB = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_sliceA = r_opA[k*CHUNK +: CHUNK];
            w_sliceB = r_opB[k*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunkAdder (
      .x     (w_sliceA),
      .y     (w_sliceB),
      .ci    (r_carry),
      .s     (w_sliceSum),
      .co    (w_sliceCo),
`ifdef MULTICYCLE_ADDER_OVF_EN
      .c_msb (w_sliceCmsb)
`else
      .c_msb ()
`endif
   );

   // Working register with the current slice sum merged into slice k; this
   // is also the value committed to sum on the final slice
   always_comb begin
      w_workNext = r_work;
      for (int k = 0; k < NCHUNK; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_workNext[k*CHUNK +: CHUNK] = w_sliceSum;
         end
      end
   end

   assign w_lastSlice = (r_idx == IDXW'(NCHUNK - 1));

   // Controller and datapath registers: capture in IDLE, one slice per RUN
   // cycle, commit on the edge into DONE, then return to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_opA   <= '0;
         r_opB   <= '0;
         r_carry <= 1'b0;
         r_work  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_opA   <= a;
                  r_opB   <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_work  <= w_workNext;
               r_carry <= w_sliceCo;
               if (w_lastSlice) begin
                  r_sum   <= w_workNext;
                  r_cout  <= w_sliceCo;
`ifdef MULTICYCLE_ADDER_OVF_EN
                  r_ovf   <= w_sliceCmsb ^ w_sliceCo;
`endif
                  r_done  <= 1'b1;
                  r_idx   <= '0;
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + IDXW'(1);
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule
